// File: rtl/l2_dbg_arbiter.sv
// Two-master arbiter sharing one L2 port between the JTAG debug bridge (dbg)
// and the SoC interconnect (soc). TCDM-style req/gnt/r_valid on all ports,
// zero added latency; read/write responses routed back to the issuing master.
module l2_dbg_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_STREAK = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    dbg_prio_i,
  // debug bridge master
  input  logic                    dbg_req_i,
  output logic                    dbg_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   dbg_add_i,
  input  logic                    dbg_we_i,
  input  logic [DATA_WIDTH/8-1:0] dbg_be_i,
  input  logic [DATA_WIDTH-1:0]   dbg_wdata_i,
  output logic                    dbg_r_valid_o,
  output logic [DATA_WIDTH-1:0]   dbg_r_rdata_o,
  // SoC interconnect master
  input  logic                    soc_req_i,
  output logic                    soc_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   soc_add_i,
  input  logic                    soc_we_i,
  input  logic [DATA_WIDTH/8-1:0] soc_be_i,
  input  logic [DATA_WIDTH-1:0]   soc_wdata_i,
  output logic                    soc_r_valid_o,
  output logic [DATA_WIDTH-1:0]   soc_r_rdata_o,
  // shared L2 port
  output logic                    l2_req_o,
  input  logic                    l2_gnt_i,
  output logic [ADDR_WIDTH-1:0]   l2_add_o,
  output logic                    l2_we_o,
  output logic [DATA_WIDTH/8-1:0] l2_be_o,
  output logic [DATA_WIDTH-1:0]   l2_wdata_o,
  input  logic                    l2_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   l2_r_rdata_i,
  output logic                    spurious_o
);

  localparam logic [7:0] STREAK_MAX = 8'(MAX_STREAK);

  typedef enum logic {
    MST_DBG = 1'b0,
    MST_SOC = 1'b1
  } master_e;

  master_e    sel;
  logic       handshake;

  logic       hold_vld_q, hold_vld_d;
  master_e    hold_own_q, hold_own_d;
  master_e    rr_q, rr_d;
  logic       pend_vld_q, pend_vld_d;
  master_e    pend_own_q, pend_own_d;
  logic [7:0] streak_q, streak_d;
  logic       spurious_q, spurious_d;

  assign l2_req_o  = dbg_req_i | soc_req_i;
  assign handshake = l2_req_o & l2_gnt_i;

  // Master selection: a stalled request keeps the port, otherwise lone
  // requester, then priority-with-guard or round-robin on a tie.
  always_comb begin
    sel = MST_DBG;
    if (hold_vld_q) begin
      sel = hold_own_q;
    end else if (soc_req_i && !dbg_req_i) begin
      sel = MST_SOC;
    end else if (soc_req_i && dbg_req_i) begin
      if (dbg_prio_i) begin
        if (streak_q == STREAK_MAX) sel = MST_SOC;
        else                        sel = MST_DBG;
      end else begin
        if (rr_q == MST_DBG) sel = MST_SOC;
        else                 sel = MST_DBG;
      end
    end
  end

  // Payload mux, grants and response routing toward the masters.
  always_comb begin
    l2_add_o      = dbg_add_i;
    l2_we_o       = dbg_we_i;
    l2_be_o       = dbg_be_i;
    l2_wdata_o    = dbg_wdata_i;
    if (sel == MST_SOC) begin
      l2_add_o    = soc_add_i;
      l2_we_o     = soc_we_i;
      l2_be_o     = soc_be_i;
      l2_wdata_o  = soc_wdata_i;
    end
    dbg_gnt_o     = handshake & (sel == MST_DBG);
    soc_gnt_o     = handshake & (sel == MST_SOC);
    dbg_r_valid_o = l2_r_valid_i & pend_vld_q & (pend_own_q == MST_DBG);
    soc_r_valid_o = l2_r_valid_i & pend_vld_q & (pend_own_q == MST_SOC);
  end

  assign dbg_r_rdata_o = l2_r_rdata_i;
  assign soc_r_rdata_o = l2_r_rdata_i;
  assign spurious_o    = spurious_q;

  // Next-state for hold, round-robin pointer, dbg streak, pending response
  // owner and the sticky spurious-response flag.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_own_d = hold_own_q;
    rr_d       = rr_q;
    streak_d   = streak_q;
    pend_vld_d = handshake;
    pend_own_d = pend_own_q;
    spurious_d = spurious_q | (l2_r_valid_i & ~pend_vld_q);

    if (handshake) begin
      hold_vld_d = 1'b0;
      rr_d       = sel;
      pend_own_d = sel;
    end else if (l2_req_o) begin
      hold_vld_d = 1'b1;
      hold_own_d = sel;
    end

    if (!soc_req_i) begin
      streak_d = '0;
    end else if (handshake && sel == MST_SOC) begin
      streak_d = '0;
    end else if (handshake && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 8'd1;
    end
  end

  // State registers; reset drops any in-flight response ownership.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q <= 1'b0;
      hold_own_q <= MST_DBG;
      rr_q       <= MST_SOC;
      pend_vld_q <= 1'b0;
      pend_own_q <= MST_DBG;
      streak_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_own_q <= hold_own_d;
      rr_q       <= rr_d;
      pend_vld_q <= pend_vld_d;
      pend_own_q <= pend_own_d;
      streak_q   <= streak_d;
      spurious_q <= spurious_d;
    end
  end

endmodule

// File: tb/tb_l2_dbg_arbiter.sv
// Scoreboard bench for l2_dbg_arbiter: stimulus predicts per-cycle outputs
// from an arbitration reference model and queues them; a negedge monitor
// compares. An L2 responder model answers every handshake one cycle later.
module tb_l2_dbg_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned MS = 8;
  localparam logic DBG = 1'b0;
  localparam logic SOC = 1'b1;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          dbg_prio_i = 1'b0;
  logic          dbg_req_i = 1'b0, soc_req_i = 1'b0;
  logic          dbg_gnt_o, soc_gnt_o;
  logic [AW-1:0] dbg_add_i = '0, soc_add_i = '0;
  logic          dbg_we_i = 1'b0, soc_we_i = 1'b0;
  logic [BW-1:0] dbg_be_i = '0, soc_be_i = '0;
  logic [DW-1:0] dbg_wdata_i = '0, soc_wdata_i = '0;
  logic          dbg_r_valid_o, soc_r_valid_o;
  logic [DW-1:0] dbg_r_rdata_o, soc_r_rdata_o;
  logic          l2_req_o;
  logic          l2_gnt_i = 1'b0;
  logic [AW-1:0] l2_add_o;
  logic          l2_we_o;
  logic [BW-1:0] l2_be_o;
  logic [DW-1:0] l2_wdata_o;
  logic          l2_r_valid_i = 1'b0;
  logic [DW-1:0] l2_r_rdata_i = '0;
  logic          spurious_o;

  always #5 clk_i = ~clk_i;

  l2_dbg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STREAK(MS)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .dbg_prio_i(dbg_prio_i),
    .dbg_req_i(dbg_req_i), .dbg_gnt_o(dbg_gnt_o), .dbg_add_i(dbg_add_i),
    .dbg_we_i(dbg_we_i), .dbg_be_i(dbg_be_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_r_valid_o(dbg_r_valid_o), .dbg_r_rdata_o(dbg_r_rdata_o),
    .soc_req_i(soc_req_i), .soc_gnt_o(soc_gnt_o), .soc_add_i(soc_add_i),
    .soc_we_i(soc_we_i), .soc_be_i(soc_be_i), .soc_wdata_i(soc_wdata_i),
    .soc_r_valid_o(soc_r_valid_o), .soc_r_rdata_o(soc_r_rdata_o),
    .l2_req_o(l2_req_o), .l2_gnt_i(l2_gnt_i), .l2_add_o(l2_add_o),
    .l2_we_o(l2_we_o), .l2_be_o(l2_be_o), .l2_wdata_o(l2_wdata_o),
    .l2_r_valid_i(l2_r_valid_i), .l2_r_rdata_i(l2_r_rdata_i),
    .spurious_o(spurious_o)
  );

  typedef struct packed {
    logic          dg, sg, req;
    logic [AW-1:0] add;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic          drv, srv, rd;
    logic [DW-1:0] rdata;
    logic          spur;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("dbg_gnt", 32'(dbg_gnt_o), 32'(e.dg));
      chk("soc_gnt", 32'(soc_gnt_o), 32'(e.sg));
      chk("l2_req", 32'(l2_req_o), 32'(e.req));
      if (e.req) begin
        chk("l2_add", l2_add_o, e.add);
        chk("l2_we", 32'(l2_we_o), 32'(e.we));
        if (e.we) begin
          chk("l2_be", 32'(l2_be_o), 32'(e.be));
          chk("l2_wdata", l2_wdata_o, e.wdata);
        end
      end
      chk("dbg_r_valid", 32'(dbg_r_valid_o), 32'(e.drv));
      chk("soc_r_valid", 32'(soc_r_valid_o), 32'(e.srv));
      if (e.rd && e.drv) chk("dbg_rdata", dbg_r_rdata_o, e.rdata);
      if (e.rd && e.srv) chk("soc_rdata", soc_r_rdata_o, e.rdata);
      chk("spurious", 32'(spurious_o), 32'(e.spur));
    end
  end

  // L2 responder: executes whatever the DUT presents on a handshake.
  logic [DW-1:0] l2_mem [8];
  logic          rsp_v = 1'b0;
  logic [DW-1:0] rsp_d = '0;
  always @(negedge clk_i) begin
    rsp_v = l2_req_o && l2_gnt_i;
    if (rsp_v) begin
      if (l2_we_o) begin
        for (int unsigned b = 0; b < BW; b++)
          if (l2_be_o[b]) l2_mem[l2_add_o[4:2]][8*b +: 8] = l2_wdata_o[8*b +: 8];
        rsp_d = '0;
      end else begin
        rsp_d = l2_mem[l2_add_o[4:2]];
      end
    end
  end

  // Master-side transaction state and the reference model.
  logic          d_busy = 1'b0, s_busy = 1'b0;
  logic [AW-1:0] d_add = '0, s_add = '0;
  logic          d_we = 1'b0, s_we = 1'b0;
  logic [BW-1:0] d_be = '0, s_be = '0;
  logic [DW-1:0] d_wd = '0, s_wd = '0;

  logic          m_owed_v, m_owed;   // master that was shown to L2 but not yet granted
  logic          m_last;             // master granted most recently
  int unsigned   m_run;              // dbg grants in a row while soc waits
  logic          m_pend_v, m_pend_own, m_pend_rd;
  logic [DW-1:0] m_pend_data;
  logic          m_spur;
  logic [DW-1:0] m_mem [8];

  task automatic rand_txn(output logic [AW-1:0] a, output logic we,
                          output logic [BW-1:0] be, output logic [DW-1:0] wd);
    a  = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
    we = 1'($urandom_range(0, 1));
    be = we ? 4'($urandom_range(1, 15)) : 4'hF;
    wd = $urandom;
  endtask

  task automatic step(input logic rst, input logic prio, input logic dnew,
                      input logic snew, input logic gnt, input logic inj);
    exp_t          e;
    logic          rv, who, hs, sreq;
    logic [AW-1:0] a;
    logic          w;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    @(posedge clk_i);
    #1;
    rst_n        = !rst;
    rv           = rsp_v | (inj & !rsp_v);
    l2_r_valid_i = rv;
    l2_r_rdata_i = (inj && !rsp_v) ? DW'($urandom) : rsp_d;
    dbg_prio_i   = prio;
    l2_gnt_i     = gnt;
    if (rst) begin
      d_busy = 1'b0; s_busy = 1'b0;
      m_owed_v = 1'b0; m_last = SOC; m_run = 0; m_pend_v = 1'b0; m_spur = 1'b0;
    end else begin
      if (dnew && !d_busy) begin d_busy = 1'b1; rand_txn(d_add, d_we, d_be, d_wd); end
      if (snew && !s_busy) begin s_busy = 1'b1; rand_txn(s_add, s_we, s_be, s_wd); end
    end
    dbg_req_i = d_busy; dbg_add_i = d_add; dbg_we_i = d_we; dbg_be_i = d_be; dbg_wdata_i = d_wd;
    soc_req_i = s_busy; soc_add_i = s_add; soc_we_i = s_we; soc_be_i = s_be; soc_wdata_i = s_wd;

    e       = '0;
    e.spur  = m_spur;
    e.drv   = rv && m_pend_v && (m_pend_own == DBG);
    e.srv   = rv && m_pend_v && (m_pend_own == SOC);
    e.rd    = m_pend_rd;
    e.rdata = m_pend_data;
    e.req   = d_busy || s_busy;
    sreq    = s_busy;
    who     = DBG;
    if (m_owed_v)               who = m_owed;
    else if (d_busy && !s_busy) who = DBG;
    else if (s_busy && !d_busy) who = SOC;
    else if (prio)              who = (m_run == MS) ? SOC : DBG;
    else                        who = (m_last == DBG) ? SOC : DBG;
    a  = (who == SOC) ? s_add : d_add;
    w  = (who == SOC) ? s_we  : d_we;
    be = (who == SOC) ? s_be  : d_be;
    wd = (who == SOC) ? s_wd  : d_wd;
    hs = e.req && gnt;
    if (e.req) begin
      e.add = a; e.we = w; e.be = be; e.wdata = wd;
      e.dg  = gnt && (who == DBG);
      e.sg  = gnt && (who == SOC);
    end
    exp_q.push_back(e);

    if (!rst) begin
      if (rv && !m_pend_v) m_spur = 1'b1;
      m_pend_v = hs;
      if (hs) begin
        m_pend_own  = who;
        m_pend_rd   = !w;
        m_pend_data = m_mem[a[4:2]];
        if (w)
          for (int unsigned b = 0; b < BW; b++)
            if (be[b]) m_mem[a[4:2]][8*b +: 8] = wd[8*b +: 8];
        m_last   = who;
        m_owed_v = 1'b0;
        if (who == DBG) d_busy = 1'b0;
        else            s_busy = 1'b0;
      end else if (e.req) begin
        m_owed_v = 1'b1;
        m_owed   = who;
      end
      if (!sreq)                    m_run = 0;
      else if (hs && who == SOC)    m_run = 0;
      else if (hs && m_run < MS)    m_run = m_run + 1;
    end
  endtask

  task automatic dbg_set(input logic [AW-1:0] a, input logic we,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    d_busy = 1'b1; d_add = a; d_we = we; d_be = be; d_wd = wd;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic prio_r;
    int unsigned dp, sp, gp;
    for (int i = 0; i < 8; i++) begin l2_mem[i] = '0; m_mem[i] = '0; end
    m_pend_rd = 1'b0; m_pend_own = DBG; m_pend_data = '0; m_owed = DBG;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // dbg alone: write then read back
    dbg_set(32'h0, 1'b1, 4'hF, 32'hABBAABBA);
    step(0, 0, 0, 0, 1, 0);
    dbg_set(32'h0, 1'b0, 4'hF, 32'h0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // round-robin with both requesting continuously
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // debug priority with starvation guard
    for (int i = 0; i < 28; i++) step(0, 1, 1, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // grant stall: soc held, dbg arrives in cycle 2
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);

    // spurious response with nothing outstanding
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // reset right after a dbg read handshake, late response after release
    dbg_set(32'h0, 1'b0, 4'hF, 32'h0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    // first tie after reset in round-robin goes to dbg
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // randomized traffic
    prio_r = 1'b0; dp = 50; sp = 50; gp = 75;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        prio_r = 1'($urandom_range(0, 1));
        dp = $urandom_range(20, 100);
        sp = $urandom_range(20, 100);
        gp = $urandom_range(30, 100);
      end
      step(0, prio_r, $urandom_range(1, 100) <= dp, $urandom_range(1, 100) <= sp,
           $urandom_range(1, 100) <= gp, 0);
    end
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_i);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_dbg_arbiter.md
Name: l2_dbg_arbiter

Overview:
Two-master arbiter sharing one single-bank L2 port between the JTAG debug bridge (dbg, fed by the PULP TAP write32/read32 path) and the SoC interconnect (soc). It sits between the TAP-side bus master and L2 and applies a TCDM-style req/gnt/r_valid protocol on all three ports. It selects either fixed debug priority with starvation guard, or round-robin, and routes each read response back to the master that issued it.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
MAX_STREAK, 8, maximum consecutive dbg grants while soc is waiting (priority mode only); range 1..255

Ports:
clk_i  in  1  clock
rst_n  in  1  asynchronous active-low reset
dbg_prio_i  in  1  1 = debug priority mode, 0 = round-robin; quasi-static, sampled every cycle
dbg_req_i / soc_req_i  in  1  request
dbg_gnt_o / soc_gnt_o  out  1  grant, same cycle as l2_gnt_i
dbg_add_i / soc_add_i  in  ADDR_WIDTH  address
dbg_we_i / soc_we_i  in  1  1 = write
dbg_be_i / soc_be_i  in  DATA_WIDTH/8  byte enables
dbg_wdata_i / soc_wdata_i  in  DATA_WIDTH  write data
dbg_r_valid_o / soc_r_valid_o  out  1  response valid
dbg_r_rdata_o / soc_r_rdata_o  out  DATA_WIDTH  response data (l2_r_rdata_i broadcast to both)
l2_req_o  out  1  request to L2
l2_gnt_i  in  1  L2 grant
l2_add_o / l2_we_o / l2_be_o / l2_wdata_o  out  as masters  muxed payload
l2_r_valid_i  in  1  L2 response, exactly 1 cycle after handshake (reads and writes)
l2_r_rdata_i  in  DATA_WIDTH  L2 read data
spurious_o  out  1  sticky: l2_r_valid_i seen with no pending response

Behaviour:
- Reset: all gnt/r_valid outputs 0, l2_req_o 0, spurious_o 0. rr_q = soc (dbg wins first tie), hold_q cleared, pend_q cleared, streak_q = 0.
- Handshake = l2_req_o & l2_gnt_i. Masters hold req and payload stable until granted.
- l2_req_o = dbg_req_i | soc_req_i, combinational. Payload muxed from the selected master. x_gnt_o = l2_gnt_i & l2_req_o & (sel == x).
- Selection, in priority order:
  1. If hold_q is valid, select hold_q's master.
  2. Otherwise, if only one master requests, select it.
  3. Both request, dbg_prio_i=1: select dbg unless streak_q == MAX_STREAK, in which case select soc.
  4. Both request, dbg_prio_i=0: select the master not equal to rr_q.
- hold_q: set to sel when l2_req_o & !l2_gnt_i. Cleared on handshake. Selection never switches while a request is waiting for grant.
- rr_q: updated to sel on every handshake.
- streak_q (saturating at MAX_STREAK):
  - +1 on a dbg handshake while soc_req_i=1.
  - Cleared on a soc handshake, or in any cycle with soc_req_i=0.
- Response routing: on handshake, pend_q <= {1, sel}; otherwise pend_q.valid <= 0. Back-to-back handshakes are supported at one per cycle.
- Next cycle: x_r_valid_o = l2_r_valid_i & pend_q.valid & (pend_q.owner == x), combinational from l2_r_valid_i.
- Spurious response: l2_r_valid_i with pend_q.valid=0 is dropped (no r_valid to either master) and sets spurious_o. spurious_o clears only on reset.
- Reset mid-transaction: any pending response is discarded, and a late l2_r_valid_i in the first cycle after reset release sets spurious_o.
- Latency: zero added cycles on request path, zero on response path.

Test Plan:
- dbg only: write 32'hABBAABBA to 0x0000_0000 with be=4'hF, then read 0x0. Required: dbg_gnt_o same cycle as l2_gnt_i, dbg_r_valid_o 1 cycle later with rdata 32'hABBAABBA, soc_r_valid_o never high.
- Round-robin (dbg_prio_i=0): both masters request continuously, l2_gnt_i=1. Required: grants alternate dbg, soc, dbg, soc…; responses route to dbg, soc, dbg, soc… one cycle later.
- Priority starvation guard (dbg_prio_i=1, MAX_STREAK=8): both request continuously. Required: 8 dbg grants, 1 soc grant, repeating; streak_q returns to 0 after each soc grant.
- Grant stall: soc requests alone with l2_gnt_i=0 for 3 cycles, dbg raises req in cycle 2. Required: payload stays soc's, soc is granted first when l2_gnt_i rises, dbg is granted on the next cycle.
- Spurious / reset: pulse l2_r_valid_i with no prior handshake → no master r_valid, spurious_o=1. Assert rst_n=0 one cycle after a dbg read handshake → all outputs 0 and spurious_o cleared immediately, no dbg_r_valid_o after release.
